// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Bus addresses: status is at KEYPAD_ADDR and the key code at KEYPAD_ADDR+1.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_e;

  localparam logic [3:0]  ROW_IDLE    = 4'hF;
  localparam logic [3:0]  ROW_RESET   = 4'b1110;
  localparam logic [11:0] KEYPAD_ADDR = 12'h500;
  localparam logic [11:0] STATUS_OFS  = 12'h000;
  localparam logic [11:0] DATA_OFS    = 12'h001;

  // Column priority: the lowest-numbered active-low column wins.
  function automatic logic [1:0] lowest_col(input logic [3:0] col);
    if (!col[0])      lowest_col = 2'd0;
    else if (!col[1]) lowest_col = 2'd1;
    else if (!col[2]) lowest_col = 2'd2;
    else              lowest_col = 2'd3;
  endfunction

  function automatic logic is_keypad_addr(input logic [11:0] addr);
    is_keypad_addr = (addr == KEYPAD_ADDR + STATUS_OFS) ||
                     (addr == KEYPAD_ADDR + DATA_OFS);
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Scan prescaler: pulses tick_o for one clock every SCAN_DIV clocks.
// The counter restarts from zero on reset so the first tick lands SCAN_DIV clocks later.
module scan_tick_gen #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(SCAN_DIV - 1));

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scanner.sv
// Memory-mapped 4x4 keypad controller: row scan, debounce, key code latch and ready flag.
//   state    | meaning
//   SCAN     | rotating the driven row, looking for any low column
//   DEBOUNCE | row frozen, counting stable samples of the candidate column
//   HELD     | key accepted, row frozen, counting released samples
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  rowwrite,
  input  logic [3:0]  colread,
  input  logic        readyclr,
  input  logic        a0,
  output logic [15:0] dataout
);

  localparam int CW = $clog2(DEBOUNCE_CNT + 1);

  state_e        state_q, state_d;
  logic [1:0]    row_q, row_d;
  logic [3:0]    rowwrite_q, rowwrite_d;
  logic [1:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    keycode_q, keycode_d;
  logic          ready_q, ready_d;

  logic          tick;
  logic          any_low;
  logic [1:0]    low_col;
  logic [CW-1:0] cnt_inc;
  logic          cnt_full;
  logic          accept;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (tick)
  );

  assign any_low  = (colread != ROW_IDLE);
  assign low_col  = lowest_col(colread);
  assign cnt_inc  = cnt_q + 1'b1;
  assign cnt_full = (cnt_inc == CW'(DEBOUNCE_CNT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= SCAN;
      row_q      <= 2'd0;
      rowwrite_q <= ROW_RESET;
      cand_q     <= 2'd0;
      cnt_q      <= '0;
      keycode_q  <= 4'd0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      rowwrite_q <= rowwrite_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      keycode_q  <= keycode_d;
      ready_q    <= ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    rowwrite_d = rowwrite_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    keycode_d  = keycode_q;
    accept     = 1'b0;

    unique case (state_q)
      SCAN: begin
        if (tick) begin
          if (!any_low) begin
            row_d      = row_q + 2'd1;
            rowwrite_d = {rowwrite_q[2:0], rowwrite_q[3]};
          end else begin
            cand_d = low_col;
            if (DEBOUNCE_CNT == 1) begin
              accept    = 1'b1;
              keycode_d = {row_q, low_col};
              cnt_d     = '0;
              state_d   = HELD;
            end else begin
              cnt_d   = CW'(1);
              state_d = DEBOUNCE;
            end
          end
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (any_low && (low_col == cand_q)) begin
            if (cnt_full) begin
              accept    = 1'b1;
              keycode_d = {row_q, cand_q};
              cnt_d     = '0;
              state_d   = HELD;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d      = '0;
            state_d    = SCAN;
            row_d      = row_q + 2'd1;
            rowwrite_d = {rowwrite_q[2:0], rowwrite_q[3]};
          end
        end
      end
      HELD: begin
        // Release must be seen on DEBOUNCE_CNT consecutive ticks; any low column restarts it.
        if (tick) begin
          if (any_low) begin
            cnt_d = '0;
          end else if (cnt_full) begin
            cnt_d      = '0;
            state_d    = SCAN;
            row_d      = row_q + 2'd1;
            rowwrite_d = {rowwrite_q[2:0], rowwrite_q[3]};
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = SCAN;
    endcase

    ready_d = accept | (ready_q & ~readyclr);
  end

  always_comb begin
    rowwrite = rowwrite_q;
    dataout  = a0 ? {12'h000, keycode_q} : {15'b0, ready_q};
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad matrix model and an expected-value queue.
module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  rowwrite;
  logic [3:0]  colread;
  logic        readyclr = 1'b0;
  logic        a0 = 1'b0;
  logic [15:0] dataout;

  logic        key_on = 1'b0;
  logic [1:0]  key_row = 2'd0;
  logic [3:0]  key_mask = 4'd0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  // Matrix model: pressed columns pull low only while their row is driven.
  always_comb colread = (key_on && !rowwrite[key_row]) ? ~key_mask : 4'hF;

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rowwrite (rowwrite),
    .colread  (colread),
    .readyclr (readyclr),
    .a0       (a0),
    .dataout  (dataout)
  );

  function automatic logic [3:0] drive_of(input int r);
    logic [3:0] v;
    v = 4'b0001 << r;
    return ~v;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_val(input string tag, input logic [15:0] v);
    exp_q.push_back('{tag, v});
  endtask

  task automatic check(input logic [15:0] obs);
    exp_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk_row(input string tag, input int r);
    expect_val(tag, {12'h000, drive_of(r)});
    check({12'h000, rowwrite});
  endtask

  task automatic chk_read(input string tag, input logic sel, input logic [15:0] v);
    a0 = sel;
    #1;
    expect_val(tag, v);
    check(dataout);
  endtask

  initial begin
    step(3);
    chk_row("rst_row", 0);
    chk_read("rst_status", 1'b0, 16'h0000);
    chk_read("rst_code", 1'b1, 16'h0000);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step(4);
      chk_row("scan_row", i % 4);
    end

    key_row = 2'd2; key_mask = 4'b0010; key_on = 1'b1;
    step(12);
    chk_row("detect_freeze", 2);
    chk_read("pre_ready", 1'b0, 16'h0000);
    step(3);
    chk_read("ready_minus1", 1'b0, 16'h0000);
    step(1);
    chk_read("accept_status", 1'b0, 16'h0001);
    chk_read("accept_code", 1'b1, 16'h0009);
    chk_row("held_freeze", 2);

    readyclr = 1'b1;
    chk_read("clr_same_cycle", 1'b0, 16'h0001);
    step(1);
    readyclr = 1'b0;
    chk_read("clr_next", 1'b0, 16'h0000);
    chk_read("clr_keep_code", 1'b1, 16'h0009);

    step(15);
    chk_read("held_no_rearm", 1'b0, 16'h0000);
    chk_row("held_row", 2);
    key_on = 1'b0;
    step(8);
    chk_row("release_resume", 3);
    key_row = 2'd3; key_mask = 4'b0001; key_on = 1'b1;
    step(8);
    chk_read("second_status", 1'b0, 16'h0001);
    chk_read("second_code", 1'b1, 16'h000C);

    key_on = 1'b0;
    step(8);
    chk_row("release2", 0);
    key_row = 2'd1; key_mask = 4'b0110; key_on = 1'b1;
    step(12);
    chk_read("overrun_status", 1'b0, 16'h0001);
    chk_read("overrun_code_lowest_col", 1'b1, 16'h0005);
    readyclr = 1'b1;
    step(1);
    readyclr = 1'b0;
    chk_read("clear2", 1'b0, 16'h0000);

    key_on = 1'b0;
    step(7);
    chk_row("release3", 2);
    key_row = 2'd2; key_mask = 4'b1000; key_on = 1'b1;
    step(7);
    readyclr = 1'b1;
    step(1);
    readyclr = 1'b0;
    chk_read("set_wins", 1'b0, 16'h0001);
    chk_read("set_wins_code", 1'b1, 16'h000B);
    readyclr = 1'b1;
    step(1);
    readyclr = 1'b0;
    chk_read("clear3", 1'b0, 16'h0000);

    key_on = 1'b0;
    step(7);
    chk_row("release4", 3);
    key_row = 2'd0; key_mask = 4'b1000; key_on = 1'b1;
    step(8);
    chk_row("bounce_detect", 0);
    key_on = 1'b0;
    step(4);
    chk_row("bounce_resume", 1);
    chk_read("bounce_no_ready", 1'b0, 16'h0000);
    step(4);
    chk_row("bounce_scan_on", 2);

    key_row = 2'd2; key_mask = 4'b0001; key_on = 1'b1;
    step(4);
    chk_row("deb_before_rst", 2);
    rst_n = 1'b0;
    step(1);
    key_on = 1'b0;
    chk_row("mid_rst_row", 0);
    chk_read("mid_rst_status", 1'b0, 16'h0000);
    chk_read("mid_rst_code", 1'b1, 16'h0000);
    rst_n = 1'b1;
    step(4);
    chk_row("post_rst_scan", 1);
    chk_read("post_rst_ready", 1'b0, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule
